mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder_mem_array.sv | 29 ++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder block.
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   PORT_ADDR : address decoded to the memory-mapped output register
//   WP_LIMIT  : highest address of the write-protected region (used only
//               when MEM_WRITE_PROTECT_EN is defined)
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] PORT_ADDR = 8'hFF;
    localparam logic [7:0] WP_LIMIT  = 8'h1F;

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// CPU-side bus between a requester and mem_responder.
//   req          : access request (master -> slave)
//   Address_out  : 8-bit access address (master -> slave)
//   Data_out     : 8-bit write data (master -> slave)
//   MW           : 1 = write, 0 = read (master -> slave)
//   Data_in      : 8-bit read data (slave -> master)
//   ready        : one-cycle transaction-complete strobe (slave -> master)
//   port_out     : memory-mapped output register (slave -> master)
//   acc_cnt      : completed-transaction counter (slave -> master)
//   err          : one-cycle protection-violation strobe (slave -> master)
// ---------------------------------------------------------------------------
interface mem_responder_if;

    logic       req;
    logic [7:0] Address_out;
    logic [7:0] Data_out;
    logic       MW;
    logic [7:0] Data_in;
    logic       ready;
    logic [7:0] port_out;
    logic [7:0] acc_cnt;
    logic       err;

    modport master (
        output req, Address_out, Data_out, MW,
        input  Data_in, ready, port_out, acc_cnt, err
    );

    modport slave (
        input  req, Address_out, Data_out, MW,
        output Data_in, ready, port_out, acc_cnt, err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array_256x8
// 256 x 8 storage: synchronous write, asynchronous (combinational) read.
// Contents have no reset.
//   clk     : clock, write happens on rising edge when we_i is high
//   we_i    : write enable
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : read data, mem[addr_i]
// ---------------------------------------------------------------------------
module mem_array_256x8 (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder. A request is captured in IDLE, held
// for WAIT_CYCLES cycles in WAIT, then performed in RESP. The access result
// (read data, ready strobe, counter, err) is registered at the end of RESP,
// so ready rises WAIT_CYCLES+1 cycles after the capture edge. Address
// PORT_ADDR reaches the port_out register instead of memory.
//
// Parameters
//   WAIT_CYCLES : wait cycles between capture and response (0..15)
// Ports
//   clk   : clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : mem_responder_if.slave (req/Address_out/Data_out/MW in,
//           Data_in/ready/port_out/acc_cnt/err out)
// Build option
//   MEM_WRITE_PROTECT_EN : when defined, writes to 8'h00..WP_LIMIT complete
//                          with ready but leave memory unchanged and pulse err
// ---------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       mw_q, mw_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic [7:0] port_q, port_d;
    logic [7:0] acc_q, acc_d;

    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       is_port;
    logic       wp_hit;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mw_d    = mw_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        port_d  = port_q;
        acc_d   = acc_q;
        mem_we  = 1'b0;

        is_port = (addr_q == PORT_ADDR);
`ifdef MEM_WRITE_PROTECT_EN
        wp_hit  = mw_q && (addr_q <= WP_LIMIT);
`else
        wp_hit  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.Address_out;
                    wdata_d = bus.Data_out;
                    mw_d    = bus.MW;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                acc_d   = acc_q + 8'd1;
                err_d   = wp_hit;
                if (mw_q) begin
                    if (is_port) begin
                        port_d = wdata_q;
                    end else begin
                        // The memory write lands on the edge that ends RESP;
                        // a reset on that edge must cancel it.
                        mem_we = !wp_hit && reset;
                    end
                end else begin
                    rdata_d = is_port ? port_q : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            port_q  <= 8'h00;
            acc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            port_q  <= port_d;
            acc_q   <= acc_d;
        end
    end

    // Captured request fields are pure data; only the FSM decides when they
    // are used, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        mw_q    <= mw_d;
    end

    mem_array_256x8 u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign bus.Data_in  = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.port_out = port_q;
    assign bus.acc_cnt  = acc_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Two instances share one clock:
//   dut1 : WAIT_CYCLES = 1
//   dut0 : WAIT_CYCLES = 0
// Honours MEM_WRITE_PROTECT_EN for the protected-write expectations.
// ---------------------------------------------------------------------------
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic clk;
    logic reset1;
    logic reset0;

    mem_responder_if if1 ();
    mem_responder_if if0 ();

    mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (if1)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Memory write-enable pulses seen on each instance
    int we0_cnt = 0;
    int we1_cnt = 0;
    always @(posedge clk) begin
        if (dut0.mem_we) we0_cnt++;
        if (dut1.mem_we) we1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One transaction on dut1; lat = edges from capture to ready (-1 on timeout).
    // Inputs are scrambled right after capture to show they are ignored.
    task automatic xact1(input logic mw, input logic [7:0] a, input logic [7:0] d, output int lat);
        @(negedge clk);
        if1.req = 1'b1; if1.MW = mw; if1.Address_out = a; if1.Data_out = d;
        @(posedge clk);
        @(negedge clk);
        if1.req = 1'b0; if1.MW = ~mw; if1.Address_out = ~a; if1.Data_out = ~d;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (if1.ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic xact0(input logic mw, input logic [7:0] a, input logic [7:0] d, output int lat);
        @(negedge clk);
        if0.req = 1'b1; if0.MW = mw; if0.Address_out = a; if0.Data_out = d;
        @(posedge clk);
        @(negedge clk);
        if0.req = 1'b0; if0.MW = ~mw; if0.Address_out = ~a; if0.Data_out = ~d;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (if0.ready) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int rdy_cnt;
        int lat_bad;
        logic [9:0] rdy_mask;
        logic [7:0] old_val;

        reset1 = 1'b0; reset0 = 1'b0;
        if1.req = 1'b0; if1.MW = 1'b0; if1.Address_out = 8'h00; if1.Data_out = 8'h00;
        if0.req = 1'b0; if0.MW = 1'b0; if0.Address_out = 8'h00; if0.Data_out = 8'h00;

        // ---- reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   dut1.state_q, IDLE);
        check("rst_ready",   if1.ready,    1'b0);
        check("rst_err",     if1.err,      1'b0);
        check("rst_data_in", if1.Data_in,  8'h00);
        check("rst_port",    if1.port_out, 8'h00);
        check("rst_acc",     if1.acc_cnt,  8'h00);
        check("rst_acc0",    if0.acc_cnt,  8'h00);
        @(negedge clk);
        reset1 = 1'b1; reset0 = 1'b1;

        // ---- WAIT_CYCLES=1: write A5 to 40, read it back
        xact1(1'b1, 8'h40, 8'hA5, lat);
        check("w40_lat",      lat,         2);
        check("w40_data_hold", if1.Data_in, 8'h00);
        xact1(1'b0, 8'h40, 8'h00, lat);
        check("r40_lat",  lat,         2);
        check("r40_data", if1.Data_in, 8'hA5);
        check("r40_acc",  if1.acc_cnt, 8'h02);
        @(posedge clk); #1;
        check("ready_one_cycle", if1.ready, 1'b0);
        xact1(1'b1, 8'h41, 8'h5A, lat);
        check("w41_data_hold", if1.Data_in, 8'hA5);
        check("w41_acc",       if1.acc_cnt, 8'h03);

        // ---- req held high for 10 edges: strobes after edges 2, 5, 8
        @(negedge clk);
        if1.req = 1'b1; if1.MW = 1'b0; if1.Address_out = 8'h40; if1.Data_out = 8'h00;
        rdy_cnt  = 0;
        rdy_mask = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (if1.ready) begin
                rdy_cnt++;
                rdy_mask[i] = 1'b1;
            end
        end
        check("hold_ready_cnt",  rdy_cnt,      3);
        check("hold_ready_mask", rdy_mask,     10'h124);
        check("hold_acc",        if1.acc_cnt,  8'h06);
        check("hold_state",      dut1.state_q, WAIT);
        @(negedge clk);
        if1.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_drain_ready", if1.ready,   1'b1);
        check("hold_drain_acc",   if1.acc_cnt, 8'h07);

        // ---- reset during WAIT of a write 77 -> 50
        xact1(1'b1, 8'h50, 8'h22, lat);
        check("w50_lat", lat, 2);
        @(negedge clk);
        if1.req = 1'b1; if1.MW = 1'b1; if1.Address_out = 8'h50; if1.Data_out = 8'h77;
        @(posedge clk); #1;
        check("abort_in_wait", dut1.state_q, WAIT);
        @(negedge clk);
        if1.req = 1'b0;
        reset1 = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", if1.ready,    1'b0);
        check("abort_acc",   if1.acc_cnt,  8'h00);
        check("abort_state", dut1.state_q, IDLE);
        check("abort_wcnt",  dut1.wcnt_q,  4'd0);
        @(negedge clk);
        reset1 = 1'b1;
        @(posedge clk); #1;
        check("abort_no_late_ready", if1.ready, 1'b0);
        xact1(1'b0, 8'h50, 8'h00, lat);
        check("abort_mem_kept", if1.Data_in, 8'h22);
        check("abort_acc_after", if1.acc_cnt, 8'h01);

        // ---- protected region write 11 -> 10
        xact1(1'b0, 8'h10, 8'h00, lat);
        old_val = if1.Data_in;
        base = we1_cnt;
        xact1(1'b1, 8'h10, 8'h11, lat);
        check("wp_lat", lat, 2);
`ifdef MEM_WRITE_PROTECT_EN
        check("wp_err",      if1.err,          1'b1);
        check("wp_no_we",    we1_cnt - base,   0);
        xact1(1'b0, 8'h10, 8'h00, lat);
        check("wp_read_old", if1.Data_in,      old_val);
`else
        check("wp_err",      if1.err,          1'b0);
        check("wp_we",       we1_cnt - base,   1);
        xact1(1'b0, 8'h10, 8'h00, lat);
        check("wp_read_new", if1.Data_in,      8'h11);
`endif
        check("wp_err_clear", if1.err, 1'b0);

        // ---- WAIT_CYCLES=0: port_out mapping at FF
        base = we0_cnt;
        xact0(1'b1, 8'hFF, 8'h3C, lat);
        check("port_w_lat",  lat,            1);
        check("port_out",    if0.port_out,   8'h3C);
        check("port_no_mem", we0_cnt - base, 0);
        xact0(1'b0, 8'hFF, 8'h00, lat);
        check("port_read",   if0.Data_in,    8'h3C);
        base = we0_cnt;
        xact0(1'b1, 8'h20, 8'h99, lat);
        check("w20_we",      we0_cnt - base, 1);
        xact0(1'b0, 8'h20, 8'h00, lat);
        check("r20_data",    if0.Data_in,    8'h99);
        check("r20_acc",     if0.acc_cnt,    8'h04);
        check("r20_port",    if0.port_out,   8'h3C);

        // ---- counter wrap: 256 writes then one read
        @(negedge clk);
        reset0 = 1'b0;
        @(posedge clk); #1;
        check("wrap_rst_acc",  if0.acc_cnt,  8'h00);
        check("wrap_rst_port", if0.port_out, 8'h00);
        @(negedge clk);
        reset0 = 1'b1;
        lat_bad = 0;
        for (int i = 0; i < 256; i++) begin
            xact0(1'b1, 8'h80, 8'(i), lat);
            if (lat != 1) lat_bad++;
        end
        check("wrap_lat_all", lat_bad,     0);
        check("wrap_acc_256", if0.acc_cnt, 8'h00);
        xact0(1'b0, 8'h80, 8'h00, lat);
        check("wrap_acc_257", if0.acc_cnt, 8'h01);
        check("wrap_data",    if0.Data_in, 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
